period_meter: RTL and testbench

Measures the period, in CLK cycles, of a slow single-bit square wave such as the MSB of the free-running adder counter, and presents each measurement on a valid/ready output. It sits directly downstream of the counter stage and turns its toggling MSB into a numeric result that a bench or host-side logic can check against the expected wrap period. It also drives a heartbeat LED.

---
 rtl/period_meter_pkg.sv | 20 ++
 rtl/sig_sync.sv | 31 +++
 rtl/period_meter.sv | 167 ++++++++++++++++
 tb/tb_period_meter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// ============================================================================
// Module      : period_meter_pkg
// Description : Shared state encoding and sizing constants for period_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package period_meter_pkg;

   localparam int unsigned c_CW_DEFAULT = 16;
   localparam int unsigned c_SYNC_DEPTH = 2;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sig_sync.sv
// ============================================================================
// Module      : sig_sync
// Description : DEPTH-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_sync #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[DEPTH-2:0], d_i};
      end
   end

   assign q_o = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// Module      : period_meter
// Description : Measures SIG_IN rising-edge period in CLK cycles and presents
//               each result on a single-entry valid/ready slot. Define
//               PERIOD_METER_SYNC_EN to add a two-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CW = c_CW_DEFAULT
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          SIG_IN,
   input  logic          PERIOD_READY,
   output logic [CW-1:0] PERIOD,
   output logic          PERIOD_SAT,
   output logic          PERIOD_VALID,
   output logic          OVERFLOW,
   output logic          LED
);

   localparam logic [CW-1:0] c_MAX = '1;
   localparam logic [CW-1:0] c_ONE = CW'(1);

   logic w_sig;

`ifdef PERIOD_METER_SYNC_EN
   localparam int unsigned c_VLD_W = c_SYNC_DEPTH + 2;

   sig_sync #(
      .DEPTH (c_SYNC_DEPTH)
   ) u_sig_sync (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .d_i    (SIG_IN),
      .q_o    (w_sig)
   );
`else
   localparam int unsigned c_VLD_W = 2;

   assign w_sig = SIG_IN;
`endif

   // vld_q tracks how far genuine post-reset samples have travelled down the
   // input path, so a level already high at reset release never looks like
   // an edge against the zeroed flops.
   logic [c_VLD_W-1:0] vld_q;
   logic               samp_q;
   logic               prev_q;
   logic               w_rise;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_q  <= '0;
         samp_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         vld_q  <= {vld_q[c_VLD_W-2:0], 1'b1};
         samp_q <= w_sig;
         prev_q <= samp_q;
      end
   end

   assign w_rise = samp_q & ~prev_q & vld_q[c_VLD_W-1];

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic            sat_q, sat_d;
   logic            w_emit;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sat_d   = sat_q;
      w_emit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_rise) begin
               count_d = c_ONE;
               sat_d   = 1'b0;
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (w_rise) begin
               w_emit  = 1'b1;
               count_d = c_ONE;
               sat_d   = 1'b0;
            end else begin
               count_d = (count_q == c_MAX) ? c_MAX : count_q + c_ONE;
               sat_d   = (count_d == c_MAX);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   logic [CW-1:0] period_q, period_d;
   logic          psat_q, psat_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          led_q, led_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         period_q <= '0;
         psat_q   <= 1'b0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         led_q    <= 1'b0;
      end else begin
         period_q <= period_d;
         psat_q   <= psat_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         led_q    <= led_d;
      end
   end

   // A slot being drained this cycle counts as free for the new result.
   always_comb begin
      period_d = period_q;
      psat_d   = psat_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      led_d    = led_q;
      if (w_emit) begin
         if (!valid_q || PERIOD_READY) begin
            period_d = count_q;
            psat_d   = sat_q;
            valid_d  = 1'b1;
            led_d    = ~led_q;
         end else begin
            ovf_d    = 1'b1;
         end
      end else if (valid_q && PERIOD_READY) begin
         valid_d = 1'b0;
      end
   end

   assign PERIOD       = period_q;
   assign PERIOD_SAT   = psat_q;
   assign PERIOD_VALID = valid_q;
   assign OVERFLOW     = ovf_q;
   assign LED          = led_q;

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// Module      : tb_period_meter
// Description : Self-checking bench for period_meter (CW=16 and CW=4 copies
//               driven by the same stimulus) against an edge-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_period_meter;

`ifdef PERIOD_METER_SYNC_EN
   localparam int c_LAT = 3;
`else
   localparam int c_LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        sig;
   logic        ready;
   logic [15:0] p16;
   logic        s16, v16, o16, l16;
   logic [3:0]  p4;
   logic        s4, v4, o4, l4;

   period_meter #(.CW(16)) u_dut16 (
      .CLK (clk), .RST_N (rst_n), .SIG_IN (sig), .PERIOD_READY (ready),
      .PERIOD (p16), .PERIOD_SAT (s16), .PERIOD_VALID (v16),
      .OVERFLOW (o16), .LED (l16)
   );

   period_meter #(.CW(4)) u_dut4 (
      .CLK (clk), .RST_N (rst_n), .SIG_IN (sig), .PERIOD_READY (ready),
      .PERIOD (p4), .PERIOD_SAT (s4), .PERIOD_VALID (v4),
      .OVERFLOW (o4), .LED (l4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 50)
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: rising edges are numbered by post-reset clock edge; each pair
   // of consecutive edges yields a result c_LAT edges after the later one.
   typedef struct {
      int due;
      int val;
   } res_t;

   res_t q[$];
   int   m_e = 0, m_last = 0, m_loads = 0, m_swaps = 0;
   bit   m_armed = 0, m_sprev = 0;
   bit   m_vld = 0, m_s16 = 0, m_s4 = 0, m_led = 0, m_ovf = 0;
   int   m_p16 = 0, m_p4 = 0;

   initial begin
      forever begin
         bit emit;
         int v;
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_e = 0; m_last = 0; m_armed = 0; m_sprev = 0;
            q.delete();
            m_vld = 0; m_p16 = 0; m_p4 = 0; m_s16 = 0; m_s4 = 0;
            m_led = 0; m_ovf = 0;
         end else begin
            m_e++;
            emit = 0;
            v    = 0;
            if (q.size() > 0 && q[0].due == m_e) begin
               emit = 1;
               v    = q[0].val;
               void'(q.pop_front());
            end
            if (m_e >= 2 && sig && !m_sprev) begin
               if (m_armed) q.push_back('{due: m_e + c_LAT, val: m_e - m_last});
               m_armed = 1;
               m_last  = m_e;
            end
            m_sprev = sig;
            if (emit) begin
               if (!m_vld || ready) begin
                  if (m_vld) m_swaps++;
                  m_p16 = (v >= 65535) ? 65535 : v;
                  m_s16 = (v >= 65535);
                  m_p4  = (v >= 15) ? 15 : v;
                  m_s4  = (v >= 15);
                  m_vld = 1;
                  m_led = ~m_led;
                  m_loads++;
               end else begin
                  m_ovf = 1;
               end
            end else if (m_vld && ready) begin
               m_vld = 0;
            end
         end
      end
   end

   bit done = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            check("p16",   32'(p16), 32'(m_p16));
            check("sat16", 32'(s16), 32'(m_s16));
            check("vld16", 32'(v16), 32'(m_vld));
            check("ovf16", 32'(o16), 32'(m_ovf));
            check("led16", 32'(l16), 32'(m_led));
            check("p4",    32'(p4),  32'(m_p4));
            check("sat4",  32'(s4),  32'(m_s4));
            check("vld4",  32'(v4),  32'(m_vld));
            check("ovf4",  32'(o4),  32'(m_ovf));
            check("led4",  32'(l4),  32'(m_led));
         end
      end
   end

   bit gate = 0;

   // Inputs change 2 time units after each rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         if (gate) ready = m_vld && (q.size() > 0) && (q[0].due == m_e + 1);
      end
   endtask

   task automatic sq(input int p, input int n);
      repeat (n) begin
         sig = 1'b1;
         cyc(p / 2);
         sig = 1'b0;
         cyc(p - p / 2);
      end
   endtask

   initial begin
      bit lb;
      int loads_before;
      rst_n = 1'b0;
      sig   = 1'b0;
      ready = 1'b1;
      cyc(3);
      check("rst_period", 32'(p16), 0);
      check("rst_valid",  32'(v16), 0);
      check("rst_led",    32'(l16), 0);
      rst_n = 1'b1;

      cyc(50);
      check("idle_valid", 32'(v16), 0);
      check("idle_led",   32'(l16), 0);
      check("idle_ovf",   32'(o16), 0);

      sq(10, 5);
      cyc(4);
      check("sq10_loads",   32'(m_loads), 4);
      check("sq10_p16",     32'(p16), 10);
      check("sq10_p4",      32'(p4), 10);
      check("sq10_sat",     32'(s16), 0);
      check("sq10_led",     32'(l16), 0);

      sq(40, 3);
      check("sq40_model4",  32'(m_p4), 15);
      check("sq40_p4",      32'(p4), 15);
      check("sq40_sat4",    32'(s4), 1);
      check("sq40_p16",     32'(p16), 40);
      check("sq40_sat16",   32'(s16), 0);

      gate = 1;
      sq(6, 4);
      gate  = 0;
      check("sq6_p4",       32'(p4), 6);
      check("sq6_sat4",     32'(s4), 0);
      check("sq6_p16",      32'(p16), 6);
      check("swap_seen",    32'(m_swaps > 0), 1);
      check("swap_valid",   32'(v16), 1);
      check("swap_ovf",     32'(o16), 0);

      ready = 1'b1;
      cyc(2);
      sq(8, 2);
      lb           = m_led;
      loads_before = m_loads;
      ready        = 1'b0;
      sq(8, 3);
      check("ovf_period",   32'(p16), 8);
      check("ovf_valid",    32'(v16), 1);
      check("ovf_flag",     32'(o16), 1);
      check("ovf_led",      32'(l16), 32'(lb ^ 1'b1));
      check("ovf_loads",    32'(m_loads - loads_before), 1);
      ready = 1'b1;
      cyc(1);
      check("drain_valid",  32'(v16), 0);
      check("drain_period", 32'(p16), 8);

      ready = 1'b0;
      sq(10, 2);
      sig = 1'b1;
      cyc(6);
      rst_n = 1'b0;
      #1;
      check("arst_period",  32'(p16), 0);
      check("arst_valid",   32'(v16), 0);
      check("arst_ovf",     32'(o16), 0);
      check("arst_led",     32'(l16), 0);
      check("arst_sat4",    32'(s4), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(5);
      sig = 1'b0;
      cyc(5);
      sq(10, 1);
      check("rearm_valid",  32'(v16), 0);
      sig = 1'b1;
      cyc(5);
      check("post_valid",   32'(v16), 1);
      check("post_period",  32'(p16), 10);
      sig = 1'b0;
      cyc(5);

      done = 1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
